// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: tag-based operand wakeup, oldest-ready select, registered issue port.
// Optional build macro RS_SCHED_PERF_EN adds the o_stall_cycles dispatch-stall counter.
module rs_issue_scheduler #(
    parameter int RS_SIZE  = 4,
    parameter int REG_SIZE = 64,
    parameter int TAG_W    = 5
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_disp_valid,
    output logic                         o_disp_ready,
    input  logic                         i_disp_op1_valid,
    input  logic [TAG_W-1:0]             i_disp_op1_tag,
    input  logic [REG_SIZE-1:0]          i_disp_op1_value,
    input  logic                         i_disp_op2_valid,
    input  logic [TAG_W-1:0]             i_disp_op2_tag,
    input  logic [REG_SIZE-1:0]          i_disp_op2_value,
    input  logic [TAG_W-1:0]             i_disp_dst_tag,
    input  logic                         i_cdb_valid,
    input  logic [TAG_W-1:0]             i_cdb_tag,
    input  logic [REG_SIZE-1:0]          i_cdb_value,
    output logic                         o_issue_valid,
    input  logic                         i_issue_ready,
    output logic [REG_SIZE-1:0]          o_issue_op1,
    output logic [REG_SIZE-1:0]          o_issue_op2,
    output logic [TAG_W-1:0]             o_issue_dst_tag,
    output logic [$clog2(RS_SIZE+1)-1:0] o_occupancy
`ifdef RS_SCHED_PERF_EN
    ,
    output logic [31:0]                  o_stall_cycles
`endif
);
    localparam int OCC_W  = $clog2(RS_SIZE + 1);
    localparam int RANK_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]  busy_q;
    logic [RS_SIZE-1:0]  op1_vld_q;
    logic [RS_SIZE-1:0]  op2_vld_q;
    logic [TAG_W-1:0]    op1_tag_q [RS_SIZE];
    logic [TAG_W-1:0]    op2_tag_q [RS_SIZE];
    logic [REG_SIZE-1:0] op1_val_q [RS_SIZE];
    logic [REG_SIZE-1:0] op2_val_q [RS_SIZE];
    logic [TAG_W-1:0]    dst_tag_q [RS_SIZE];
    logic [RANK_W-1:0]   rank_q    [RS_SIZE];

    logic                occ_unused_hi;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                issue_valid_q;
    logic [REG_SIZE-1:0] issue_op1_q, issue_op2_q;
    logic [TAG_W-1:0]    issue_dst_q;

    logic                disp_ready;
    logic                disp_fire;
    logic                can_load;
    logic                issue_fire;
    logic                sel_found, free_found;
    logic [RANK_W-1:0]   sel_idx, sel_rank, free_idx, new_rank;
    logic                disp_op1_vld, disp_op2_vld;
    logic [REG_SIZE-1:0] disp_op1_val, disp_op2_val;

    assign disp_ready = (occ_q != OCC_W'(RS_SIZE));
    assign can_load   = !issue_valid_q || i_issue_ready;

    // Oldest-ready select uses pre-edge operand state, so a wakeup is visible one cycle later.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_rank   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && op1_vld_q[i] && op2_vld_q[i] &&
                (!sel_found || rank_q[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = RANK_W'(i);
                sel_rank  = rank_q[i];
            end
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = RANK_W'(i);
            end
        end
    end

    assign issue_fire = can_load && sel_found;
    assign disp_fire  = i_disp_valid && disp_ready && free_found;

    // A same-cycle issue shifts every younger rank down, so the newcomer lands one slot lower.
    assign occ_unused_hi = 1'b0;
    assign new_rank = issue_fire ? RANK_W'(occ_q - OCC_W'(1)) : RANK_W'(occ_q);
    assign occ_d    = occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);

    // CDB bypass into the dispatch slot.
    assign disp_op1_vld = i_disp_op1_valid || (i_cdb_valid && i_disp_op1_tag == i_cdb_tag);
    assign disp_op2_vld = i_disp_op2_valid || (i_cdb_valid && i_disp_op2_tag == i_cdb_tag);
    assign disp_op1_val = i_disp_op1_valid ? i_disp_op1_value : i_cdb_value;
    assign disp_op2_val = i_disp_op2_valid ? i_disp_op2_value : i_cdb_value;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            occ_q         <= '0;
            if (i_reset) begin
                issue_op1_q <= '0;
                issue_op2_q <= '0;
                issue_dst_q <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    if (i_cdb_valid && !op1_vld_q[i] && op1_tag_q[i] == i_cdb_tag) begin
                        op1_vld_q[i] <= 1'b1;
                        op1_val_q[i] <= i_cdb_value;
                    end
                    if (i_cdb_valid && !op2_vld_q[i] && op2_tag_q[i] == i_cdb_tag) begin
                        op2_vld_q[i] <= 1'b1;
                        op2_val_q[i] <= i_cdb_value;
                    end
                    if (issue_fire && rank_q[i] > sel_rank) begin
                        rank_q[i] <= rank_q[i] - RANK_W'(1);
                    end
                end
            end
            if (issue_fire) begin
                busy_q[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                busy_q[free_idx]    <= 1'b1;
                op1_vld_q[free_idx] <= disp_op1_vld;
                op1_tag_q[free_idx] <= i_disp_op1_tag;
                op1_val_q[free_idx] <= disp_op1_val;
                op2_vld_q[free_idx] <= disp_op2_vld;
                op2_tag_q[free_idx] <= i_disp_op2_tag;
                op2_val_q[free_idx] <= disp_op2_val;
                dst_tag_q[free_idx] <= i_disp_dst_tag;
                rank_q[free_idx]    <= new_rank;
            end
            if (can_load) begin
                issue_valid_q <= sel_found;
                if (sel_found) begin
                    issue_op1_q <= op1_val_q[sel_idx];
                    issue_op2_q <= op2_val_q[sel_idx];
                    issue_dst_q <= dst_tag_q[sel_idx];
                end
            end
        end
    end

`ifdef RS_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    assign stall_d = (i_disp_valid && !disp_ready && stall_q != 32'hFFFF_FFFF) ?
                     stall_q + 32'd1 : stall_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cycles = stall_q;
`endif

    assign o_disp_ready    = disp_ready;
    assign o_occupancy     = occ_q | OCC_W'(occ_unused_hi);
    assign o_issue_valid   = issue_valid_q;
    assign o_issue_op1     = issue_op1_q;
    assign o_issue_op2     = issue_op2_q;
    assign o_issue_dst_tag = issue_dst_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: vector table of single-op dispatches plus ordering/stall/flush sequences.
module tb_rs_issue_scheduler;
    localparam int RS_SIZE  = 4;
    localparam int REG_SIZE = 64;
    localparam int TAG_W    = 5;

    logic                i_clk = 1'b0;
    logic                i_reset, i_flush;
    logic                i_disp_valid, o_disp_ready;
    logic                i_disp_op1_valid, i_disp_op2_valid;
    logic [TAG_W-1:0]    i_disp_op1_tag, i_disp_op2_tag, i_disp_dst_tag;
    logic [REG_SIZE-1:0] i_disp_op1_value, i_disp_op2_value;
    logic                i_cdb_valid;
    logic [TAG_W-1:0]    i_cdb_tag;
    logic [REG_SIZE-1:0] i_cdb_value;
    logic                o_issue_valid, i_issue_ready;
    logic [REG_SIZE-1:0] o_issue_op1, o_issue_op2;
    logic [TAG_W-1:0]    o_issue_dst_tag;
    logic [2:0]          o_occupancy;

    rs_issue_scheduler #(.RS_SIZE(RS_SIZE), .REG_SIZE(REG_SIZE), .TAG_W(TAG_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_disp_valid(i_disp_valid), .o_disp_ready(o_disp_ready),
        .i_disp_op1_valid(i_disp_op1_valid), .i_disp_op1_tag(i_disp_op1_tag),
        .i_disp_op1_value(i_disp_op1_value),
        .i_disp_op2_valid(i_disp_op2_valid), .i_disp_op2_tag(i_disp_op2_tag),
        .i_disp_op2_value(i_disp_op2_value),
        .i_disp_dst_tag(i_disp_dst_tag),
        .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_value(i_cdb_value),
        .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
        .o_issue_op1(o_issue_op1), .o_issue_op2(o_issue_op2),
        .o_issue_dst_tag(o_issue_dst_tag), .o_occupancy(o_occupancy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  dst;
    } exp_t;

    typedef struct {
        logic        o1v;
        logic [4:0]  o1t;
        logic [63:0] o1d;
        logic        o2v;
        logic [4:0]  o2t;
        logic [63:0] o2d;
        logic [4:0]  dst;
        logic        cv;
        logic [4:0]  ct;
        logic [63:0] cd;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [4:0]  ed;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_disp_valid     = 1'b0;
        i_disp_op1_valid = 1'b0;
        i_disp_op1_tag   = '0;
        i_disp_op1_value = '0;
        i_disp_op2_valid = 1'b0;
        i_disp_op2_tag   = '0;
        i_disp_op2_value = '0;
        i_disp_dst_tag   = '0;
        i_cdb_valid      = 1'b0;
        i_cdb_tag        = '0;
        i_cdb_value      = '0;
    endtask

    task automatic set_disp(input logic o1v, input logic [4:0] o1t, input logic [63:0] o1d,
                            input logic o2v, input logic [4:0] o2t, input logic [63:0] o2d,
                            input logic [4:0] dst);
        i_disp_valid     = 1'b1;
        i_disp_op1_valid = o1v;
        i_disp_op1_tag   = o1t;
        i_disp_op1_value = o1d;
        i_disp_op2_valid = o2v;
        i_disp_op2_tag   = o2t;
        i_disp_op2_value = o2d;
        i_disp_dst_tag   = dst;
    endtask

    task automatic disp(input logic o1v, input logic [4:0] o1t, input logic [63:0] o1d,
                        input logic o2v, input logic [4:0] o2t, input logic [63:0] o2d,
                        input logic [4:0] dst);
        set_disp(o1v, o1t, o1d, o2v, o2t, o2d, dst);
        tick();
        idle();
    endtask

    // An op leaves the issue register at the next edge whenever valid and ready are both high.
    always @(negedge i_clk) begin
        if (o_issue_valid && i_issue_ready && !i_reset && !i_flush) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_issue: got dst %0d expected no issue", o_issue_dst_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_op1", o_issue_op1, e.op1);
                chk("sb_op2", o_issue_op2, e.op2);
                chk("sb_dst", 64'(o_issue_dst_tag), 64'(e.dst));
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 5'd0, 64'd5, 1'b1, 5'd0, 64'd7, 5'd3,
                    1'b0, 5'd0, 64'd0, 64'd5, 64'd7, 5'd3};
        vecs[1] = '{1'b0, 5'd4, 64'd0, 1'b1, 5'd0, 64'd9, 5'd1,
                    1'b1, 5'd4, 64'h11, 64'h11, 64'd9, 5'd1};
        vecs[2] = '{1'b1, 5'd0, 64'hAA, 1'b0, 5'd12, 64'd0, 5'd2,
                    1'b1, 5'd12, 64'd42, 64'hAA, 64'd42, 5'd2};
        vecs[3] = '{1'b0, 5'd7, 64'd0, 1'b0, 5'd7, 64'd0, 5'd31,
                    1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31};
        vecs[4] = '{1'b1, 5'd5, 64'h123, 1'b1, 5'd5, 64'h456, 5'd0,
                    1'b1, 5'd5, 64'h99, 64'h123, 64'h456, 5'd0};

        idle();
        i_flush       = 1'b0;
        i_issue_ready = 1'b0;
        i_reset       = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        chk("rst_valid", 64'(o_issue_valid), 0);
        chk("rst_occ", 64'(o_occupancy), 0);
        chk("rst_ready", 64'(o_disp_ready), 1);

        // Single-op vectors, including same-cycle CDB bypass.
        i_issue_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            chk("vec_disp_ready", 64'(o_disp_ready), 1);
            set_disp(vecs[v].o1v, vecs[v].o1t, vecs[v].o1d,
                     vecs[v].o2v, vecs[v].o2t, vecs[v].o2d, vecs[v].dst);
            i_cdb_valid = vecs[v].cv;
            i_cdb_tag   = vecs[v].ct;
            i_cdb_value = vecs[v].cd;
            sb.push_back('{vecs[v].e1, vecs[v].e2, vecs[v].ed});
            tick();
            idle();
            chk("vec_occ_after_disp", 64'(o_occupancy), 1);
            chk("vec_not_yet_valid", 64'(o_issue_valid), 0);
            tick();
            chk("vec_issue_valid", 64'(o_issue_valid), 1);
            chk("vec_occ_after_issue", 64'(o_occupancy), 0);
            tick();
            chk("vec_drained", 64'(o_issue_valid), 0);
        end

        // Younger ready op overtakes an older waiting one; wakeup then releases the older.
        disp(1'b0, 5'd9, 64'd0, 1'b1, 5'd0, 64'd2, 5'd10);
        sb.push_back('{64'd3, 64'd4, 5'd11});
        disp(1'b1, 5'd0, 64'd3, 1'b1, 5'd0, 64'd4, 5'd11);
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 5'd9;
        i_cdb_value = 64'h100;
        sb.push_back('{64'h100, 64'd2, 5'd10});
        tick();
        idle();
        chk("order_first_dst", 64'(o_issue_dst_tag), 11);
        tick();
        chk("order_second_dst", 64'(o_issue_dst_tag), 10);
        chk("order_second_op1", o_issue_op1, 64'h100);
        tick();
        chk("order_drained", 64'(o_issue_valid), 0);
        chk("order_occ", 64'(o_occupancy), 0);

        // Fill to capacity with the FU stalled.
        i_issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{64'h30 + 64'(i), 64'h40 + 64'(i), 5'(20 + i)});
            disp(1'b1, 5'd0, 64'h30 + 64'(i), 1'b1, 5'd0, 64'h40 + 64'(i), 5'(20 + i));
        end
        chk("fill_occ3", 64'(o_occupancy), 3);
        chk("fill_head_dst", 64'(o_issue_dst_tag), 20);
        sb.push_back('{64'h34, 64'h44, 5'd24});
        disp(1'b1, 5'd0, 64'h34, 1'b1, 5'd0, 64'h44, 5'd24);
        chk("fill_occ4", 64'(o_occupancy), 4);
        chk("fill_not_ready", 64'(o_disp_ready), 0);
        disp(1'b1, 5'd0, 64'h35, 1'b1, 5'd0, 64'h45, 5'd25);
        chk("fill_drop_occ", 64'(o_occupancy), 4);
        chk("fill_drop_not_ready", 64'(o_disp_ready), 0);
        i_issue_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("fill_drain_occ", 64'(o_occupancy), 0);
        chk("fill_drain_valid", 64'(o_issue_valid), 0);

        // Flush squashes entries and the issue register; the issued data holds.
        i_issue_ready = 1'b0;
        disp(1'b1, 5'd0, 64'h50, 1'b1, 5'd0, 64'h51, 5'd26);
        disp(1'b0, 5'd14, 64'd0, 1'b1, 5'd0, 64'd1, 5'd27);
        disp(1'b1, 5'd0, 64'd2, 1'b0, 5'd15, 64'd0, 5'd28);
        disp(1'b0, 5'd16, 64'd0, 1'b0, 5'd16, 64'd0, 5'd29);
        chk("flush_pre_occ", 64'(o_occupancy), 3);
        chk("flush_pre_valid", 64'(o_issue_valid), 1);
        i_flush = 1'b1;
        set_disp(1'b1, 5'd0, 64'h60, 1'b1, 5'd0, 64'h61, 5'd30);
        i_cdb_valid = 1'b1;
        i_cdb_tag   = 5'd14;
        i_cdb_value = 64'h77;
        tick();
        i_flush = 1'b0;
        idle();
        chk("flush_valid", 64'(o_issue_valid), 0);
        chk("flush_occ", 64'(o_occupancy), 0);
        chk("flush_disp_ready", 64'(o_disp_ready), 1);
        chk("flush_hold_dst", 64'(o_issue_dst_tag), 26);
        i_issue_ready = 1'b1;
        for (int t = 14; t <= 16; t++) begin
            i_cdb_valid = 1'b1;
            i_cdb_tag   = 5'(t);
            i_cdb_value = 64'(t);
            tick();
        end
        idle();
        tick();
        tick();
        chk("flush_no_issue", 64'(o_issue_valid), 0);
        chk("flush_no_occ", 64'(o_occupancy), 0);

        // Back-pressure holds the issue register stable.
        i_issue_ready = 1'b0;
        sb.push_back('{64'd1, 64'd2, 5'd24});
        disp(1'b1, 5'd0, 64'd1, 1'b1, 5'd0, 64'd2, 5'd24);
        sb.push_back('{64'd3, 64'd4, 5'd25});
        disp(1'b1, 5'd0, 64'd3, 1'b1, 5'd0, 64'd4, 5'd25);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 64'(o_issue_valid), 1);
            chk("stall_dst", 64'(o_issue_dst_tag), 24);
            chk("stall_op1", o_issue_op1, 64'd1);
            tick();
        end
        i_issue_ready = 1'b1;
        tick();
        chk("stall_next_dst", 64'(o_issue_dst_tag), 25);
        chk("stall_next_valid", 64'(o_issue_valid), 1);
        tick();
        chk("stall_drained", 64'(o_issue_valid), 0);

        // Reset clears the issue data registers.
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rst2_op1", o_issue_op1, 64'd0);
        chk("rst2_dst", 64'(o_issue_dst_tag), 0);
        chk("rst2_occ", 64'(o_occupancy), 0);

        chk("sb_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
